array_shift_unit: RTL and testbench

//  Multi-cycle heap-array engine for the zero VM FPGA target: owns NArrays areas of NArea elements plus per-array sizes.

---
 rtl/array_shift_unit.sv | 213 +++++++++++++++++++++
 tb/tb_array_shift_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/array_shift_unit.sv
// Multi-cycle heap-array engine: READ / WRITE / SHIFT_UP (insert) / SHIFT_DOWN (delete), one element moved per clock.
// Optional macro ARRAY_SHIFT_TRUNCATE_EN lets SHIFT_UP on a full array discard the last element instead of erroring.
module array_shift_unit #(
    parameter int MemoryElementWidth = 12,
    parameter int NArea              = 4,
    parameter int NArrays            = 2,
    localparam int AW = (NArrays > 1) ? $clog2(NArrays) : 1,
    localparam int IW = $clog2(NArea + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          request,
    input  logic [1:0]                    op,
    input  logic [AW-1:0]                 array,
    input  logic [IW-1:0]                 index,
    input  logic [MemoryElementWidth-1:0] data_in,
    output logic                          ready,
    output logic                          done,
    output logic                          error,
    output logic [MemoryElementWidth-1:0] data_out,
    output logic [IW-1:0]                 size_out
);

    localparam int HAW = (NArea * NArrays > 1) ? $clog2(NArea * NArrays) : 1;
    localparam int HD  = 1 << HAW;
    localparam int SD  = 1 << AW;

    localparam logic [IW-1:0] NA  = IW'(NArea);
    localparam logic [IW-1:0] ONE = IW'(1);

    localparam logic [1:0] OP_READ       = 2'd0;
    localparam logic [1:0] OP_WRITE      = 2'd1;
    localparam logic [1:0] OP_SHIFT_UP   = 2'd2;
    localparam logic [1:0] OP_SHIFT_DOWN = 2'd3;

    typedef enum logic [1:0] {IDLE, MOVE, FINISH} state_t;

    state_t state, state_nxt;

    logic [MemoryElementWidth-1:0] heap [HD];
    logic [IW-1:0]                 sizes [SD];

    // Request fields captured at the accept edge; the op runs from these only.
    logic [1:0]                    op_p0;
    logic [AW-1:0]                 arr_p0;
    logic [IW-1:0]                 idx_p0;
    logic [MemoryElementWidth-1:0] din_p0;
    logic [IW-1:0]                 size_p0;
    logic [IW-1:0]                 top_p0;
    logic [IW-1:0]                 k_p0;
    logic                          err_p0;
    logic [IW-1:0]                 cnt;

    logic          accept;
    logic          first_edge;
    logic [IW-1:0] cur_size;
    logic [IW-1:0] req_top;
    logic [IW-1:0] req_k;
    logic          req_err;

    logic                          we;
    logic [HAW-1:0]                waddr;
    logic [MemoryElementWidth-1:0] wdata;
    logic [IW-1:0]                 src;
    logic [IW-1:0]                 dst;

    function automatic logic [HAW-1:0] heap_addr(input logic [AW-1:0] a, input logic [IW-1:0] i);
        return HAW'(int'(a) * NArea + int'(i));
    endfunction

    function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] s);
        return (s >= NA) ? NA : s + ONE;
    endfunction

    function automatic logic [IW-1:0] sat_dec(input logic [IW-1:0] s);
        return (s == '0) ? '0 : s - ONE;
    endfunction

    assign cur_size = sizes[array];

    // Legality check and move count are decided from the live inputs at the accept edge.
    always_comb begin
        req_err = 1'b0;
        req_top = cur_size;
        req_k   = '0;
        if (int'(array) >= NArrays) begin
            req_err = 1'b1;
        end else begin
            case (op)
                OP_READ:  req_err = (index >= cur_size);
                OP_WRITE: req_err = (index >= NA);
                OP_SHIFT_UP: begin
`ifdef ARRAY_SHIFT_TRUNCATE_EN
                    req_err = (index > cur_size) || (index >= NA);
                    if (cur_size == NA) req_top = NA - ONE;
`else
                    req_err = (index > cur_size) || (cur_size >= NA);
`endif
                    if (!req_err) req_k = req_top - index;
                end
                default: begin
                    req_err = (index >= cur_size);
                    if (!req_err) req_k = cur_size - ONE - index;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (req_k == '0) ? FINISH : MOVE;
            MOVE:    if (cnt == k_p0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready      = (state == IDLE);
        accept     = (state == IDLE) && request;
        first_edge = ((state == MOVE) && (cnt == ONE)) || ((state == FINISH) && (k_p0 == '0));
    end

    // Insert walks downward from the top slot, delete walks upward from the hole.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = din_p0;
        if (op_p0 == OP_SHIFT_UP) begin
            src = top_p0 - cnt;
            dst = src + ONE;
        end else begin
            src = idx_p0 + cnt;
            dst = src - ONE;
        end
        if (!reset) begin
            case (state)
                MOVE: begin
                    we    = 1'b1;
                    waddr = heap_addr(arr_p0, dst);
                    wdata = heap[heap_addr(arr_p0, src)];
                end
                FINISH: begin
                    if (!err_p0 && (op_p0 == OP_WRITE || op_p0 == OP_SHIFT_UP)) begin
                        we    = 1'b1;
                        waddr = heap_addr(arr_p0, idx_p0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            op_p0   <= op;
            arr_p0  <= array;
            idx_p0  <= index;
            din_p0  <= data_in;
            size_p0 <= cur_size;
            top_p0  <= req_top;
            k_p0    <= req_k;
            err_p0  <= req_err;
            cnt     <= ONE;
        end else if (state == MOVE) begin
            cnt <= cnt + ONE;
        end
        if (we) heap[waddr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done     <= 1'b0;
            error    <= 1'b0;
            data_out <= '0;
            size_out <= '0;
            for (int s = 0; s < SD; s++) sizes[s] <= '0;
        end else begin
            done <= 1'b0;
            if (first_edge && (op_p0 == OP_SHIFT_DOWN) && !err_p0)
                data_out <= heap[heap_addr(arr_p0, idx_p0)];
            if (state == FINISH) begin
                done     <= 1'b1;
                error    <= err_p0;
                size_out <= size_p0;
                if (!err_p0) begin
                    case (op_p0)
                        OP_READ: data_out <= heap[heap_addr(arr_p0, idx_p0)];
                        OP_WRITE: begin
                            sizes[arr_p0] <= (idx_p0 >= size_p0) ? idx_p0 + ONE : size_p0;
                            size_out      <= (idx_p0 >= size_p0) ? idx_p0 + ONE : size_p0;
                        end
                        OP_SHIFT_UP: begin
                            sizes[arr_p0] <= sat_inc(size_p0);
                            size_out      <= sat_inc(size_p0);
                        end
                        default: begin
                            sizes[arr_p0] <= sat_dec(size_p0);
                            size_out      <= sat_dec(size_p0);
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_array_shift_unit.sv
// Directed bench for array_shift_unit: vector table plus busy-request and mid-op reset sequences.
// Expectations follow ARRAY_SHIFT_TRUNCATE_EN when the bench is built with it.
module tb_array_shift_unit;

    localparam int W     = 12;
    localparam int NAREA = 4;
    localparam int NARR  = 2;
    localparam int AW    = 1;
    localparam int IW    = 3;

`ifdef ARRAY_SHIFT_TRUNCATE_EN
    localparam bit TRUNC = 1'b1;
`else
    localparam bit TRUNC = 1'b0;
`endif

    localparam logic [1:0] RD = 2'd0;
    localparam logic [1:0] WR = 2'd1;
    localparam logic [1:0] SU = 2'd2;
    localparam logic [1:0] SD = 2'd3;

    logic          clock = 1'b0;
    logic          reset;
    logic          request;
    logic [1:0]    op;
    logic [AW-1:0] array;
    logic [IW-1:0] index;
    logic [W-1:0]  data_in;
    logic          ready;
    logic          done;
    logic          error;
    logic [W-1:0]  data_out;
    logic [IW-1:0] size_out;

    always #5 clock = ~clock;

    array_shift_unit #(
        .MemoryElementWidth(W),
        .NArea(NAREA),
        .NArrays(NARR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .request(request),
        .op(op),
        .array(array),
        .index(index),
        .data_in(data_in),
        .ready(ready),
        .done(done),
        .error(error),
        .data_out(data_out),
        .size_out(size_out)
    );

    typedef struct {
        logic [1:0]  op;
        logic        a;
        logic [2:0]  idx;
        logic [11:0] din;
        logic        err;
        logic        chk;
        logic [11:0] dout;
        logic [2:0]  sz;
        int          lat;
    } vec_t;

    vec_t vecs[30];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] o, input logic a, input logic [2:0] i,
                                input logic [11:0] d, input logic e, input logic c,
                                input logic [11:0] q, input logic [2:0] s, input int l);
        vec_t v;
        v.op = o; v.a = a; v.idx = i; v.din = d; v.err = e;
        v.chk = c; v.dout = q; v.sz = s; v.lat = l;
        return v;
    endfunction

    task automatic wait_ready(input string name);
        int w;
        w = 0;
        while (!ready && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        if (!ready) check({name, "_ready_timeout"}, 0, 1);
    endtask

    // Issues one op, scrambles the inputs after acceptance, returns cycles from accept to done.
    task automatic run_op(input string name, input logic [1:0] o, input logic a,
                          input logic [2:0] i, input logic [11:0] d, output int lat);
        wait_ready(name);
        request = 1'b1; op = o; array = a; index = i; data_in = d;
        @(posedge clock); #1;
        request = 1'b0; op = ~o; index = 3'd0; data_in = 12'hFFF; array = ~a;
        check({name, "_busy"}, {30'd0, ready, done}, 32'd0);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!done && lat < 20);
        if (!done) check({name, "_done_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        string nm;

        vecs[0]  = mk(WR, 1, 0, 0,  0, 0, 0,  1, 1);
        vecs[1]  = mk(WR, 1, 1, 1,  0, 0, 0,  2, 1);
        vecs[2]  = mk(WR, 1, 2, 2,  0, 0, 0,  3, 1);
        vecs[3]  = mk(SU, 1, 0, 99, 0, 0, 0,  4, 4);
        vecs[4]  = mk(RD, 1, 0, 0,  0, 1, 99, 4, 1);
        vecs[5]  = mk(RD, 1, 1, 0,  0, 1, 0,  4, 1);
        vecs[6]  = mk(RD, 1, 2, 0,  0, 1, 1,  4, 1);
        vecs[7]  = mk(RD, 1, 3, 0,  0, 1, 2,  4, 1);
        vecs[8]  = mk(WR, 0, 0, 5,  0, 0, 0,  1, 1);
        vecs[9]  = mk(SD, 0, 0, 0,  0, 1, 5,  0, 1);
        vecs[10] = mk(RD, 0, 0, 0,  1, 0, 0,  0, 1);
        vecs[11] = mk(SD, 0, 0, 0,  1, 0, 0,  0, 1);
        vecs[12] = mk(SU, 0, 1, 3,  1, 0, 0,  0, 1);
        vecs[13] = mk(SU, 0, 0, 8,  0, 0, 0,  1, 1);
        vecs[14] = mk(SU, 0, 1, 6,  0, 0, 0,  2, 1);
        vecs[15] = mk(SU, 0, 1, 4,  0, 0, 0,  3, 2);
        vecs[16] = mk(RD, 0, 1, 0,  0, 1, 4,  3, 1);
        vecs[17] = mk(RD, 0, 2, 0,  0, 1, 6,  3, 1);
        vecs[18] = mk(WR, 0, 4, 1,  1, 0, 0,  3, 1);
        vecs[19] = mk(RD, 1, 3, 0,  0, 1, 2,  4, 1);
        vecs[20] = mk(SU, 1, 0, 7,  TRUNC ? 1'b0 : 1'b1, 0, 0, 4, TRUNC ? 4 : 1);
        vecs[21] = mk(RD, 1, 0, 0,  0, 1, TRUNC ? 12'd7 : 12'd99, 4, 1);
        vecs[22] = mk(RD, 1, 3, 0,  0, 1, TRUNC ? 12'd1 : 12'd2,  4, 1);
        vecs[23] = mk(SD, 1, 1, 0,  0, 1, TRUNC ? 12'd99 : 12'd0, 3, 3);
        vecs[24] = mk(RD, 1, 0, 0,  0, 1, TRUNC ? 12'd7 : 12'd99, 3, 1);
        vecs[25] = mk(RD, 1, 1, 0,  0, 1, TRUNC ? 12'd0 : 12'd1,  3, 1);
        vecs[26] = mk(RD, 1, 2, 0,  0, 1, TRUNC ? 12'd1 : 12'd2,  3, 1);
        vecs[27] = mk(RD, 1, 3, 0,  1, 0, 0,  3, 1);
        vecs[28] = mk(WR, 1, 1, 11, 0, 0, 0,  3, 1);
        vecs[29] = mk(RD, 1, 1, 0,  0, 1, 11, 3, 1);

        reset = 1'b1; request = 1'b0; op = RD; array = '0; index = '0; data_in = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_ready",    ready,    1);
        check("rst_done",     done,     0);
        check("rst_error",    error,    0);
        check("rst_data_out", data_out, 0);
        check("rst_size_out", size_out, 0);

        for (int v = 0; v < 30; v++) begin
            nm = $sformatf("vec%0d", v);
            run_op(nm, vecs[v].op, vecs[v].a, vecs[v].idx, vecs[v].din, lat);
            check({nm, "_lat"},   lat,      vecs[v].lat);
            check({nm, "_error"}, error,    vecs[v].err);
            check({nm, "_size"},  size_out, vecs[v].sz);
            if (vecs[v].chk) check({nm, "_data"}, data_out, vecs[v].dout);
        end

        // Requests held while busy must be dropped, not queued.
        wait_ready("busy_seq");
        request = 1'b1; op = SU; array = 1'b0; index = 3'd0; data_in = 12'd2;
        @(posedge clock); #1;
        op = WR; index = 3'd3; data_in = 12'd77;
        check("busy_ready_e0", ready, 0);
        @(posedge clock); #1;
        check("busy_ready_e1", ready, 0);
        request = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        check("busy_lat",   lat,      4);
        check("busy_error", error,    0);
        check("busy_size",  size_out, 4);
        @(posedge clock); #1;
        check("done_pulse", done, 0);
        run_op("busy_rd3", RD, 1'b0, 3'd3, 12'd0, lat);
        check("busy_rd3_data", data_out, 6);
        check("busy_rd3_size", size_out, 4);
        run_op("busy_rd0", RD, 1'b0, 3'd0, 12'd0, lat);
        check("busy_rd0_data", data_out, 2);

        // Reset one cycle into a multi-cycle SHIFT_UP.
        wait_ready("rst_seq");
        request = 1'b1; op = SU; array = 1'b1; index = 3'd0; data_in = 12'd5;
        @(posedge clock); #1;
        request = 1'b0; reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_ready", ready,    1);
        check("midrst_done",  done,     0);
        check("midrst_size",  size_out, 0);
        run_op("midrst_rd1", RD, 1'b1, 3'd0, 12'd0, lat);
        check("midrst_rd1_err",  error,    1);
        check("midrst_rd1_lat",  lat,      1);
        check("midrst_rd1_size", size_out, 0);
        run_op("midrst_rd0", RD, 1'b0, 3'd0, 12'd0, lat);
        check("midrst_rd0_err",  error,    1);
        check("midrst_rd0_size", size_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
